// File: rtl/ad7606_frame_pack.sv
// rtl/ad7606_frame_pack.sv - gathers one sample per AD7606 channel and streams it as a 20-byte framed packet.
// Optional build macro AD_FRAME_CRC8_EN swaps the additive checksum for CRC-8 (poly 0x07).
module ad7606_frame_pack #(
    parameter logic [7:0] HEAD_0 = 8'hA5,
    parameter logic [7:0] HEAD_1 = 8'h5A
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_user_data_1,
    input  logic [15:0] i_user_data_2,
    input  logic [15:0] i_user_data_3,
    input  logic [15:0] i_user_data_4,
    input  logic [15:0] i_user_data_5,
    input  logic [15:0] i_user_data_6,
    input  logic [15:0] i_user_data_7,
    input  logic [15:0] i_user_data_8,
    input  logic        i_user_valid_1,
    input  logic        i_user_valid_2,
    input  logic        i_user_valid_3,
    input  logic        i_user_valid_4,
    input  logic        i_user_valid_5,
    input  logic        i_user_valid_6,
    input  logic        i_user_valid_7,
    input  logic        i_user_valid_8,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_tx_last,
    output logic        o_overrun,
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_SEQ,
        S_DATA,
        S_CSUM
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] w_data [8];
    logic [7:0]  w_valid;
    logic [15:0] r_hold [8];
    logic [15:0] r_buf  [8];
    logic [7:0]  r_flag;
    logic [7:0]  r_seq;
    logic [7:0]  r_csum;
    logic [3:0]  r_idx;
    logic        r_overrun;
    logic [7:0]  r_drop_cnt;
    logic        w_full;
    logic        w_accept;
    logic [7:0]  w_data_byte;
    logic [7:0]  w_csum_first;
    logic [7:0]  w_csum_step;

    assign w_data[0] = i_user_data_1;
    assign w_data[1] = i_user_data_2;
    assign w_data[2] = i_user_data_3;
    assign w_data[3] = i_user_data_4;
    assign w_data[4] = i_user_data_5;
    assign w_data[5] = i_user_data_6;
    assign w_data[6] = i_user_data_7;
    assign w_data[7] = i_user_data_8;
    assign w_valid   = {i_user_valid_8, i_user_valid_7, i_user_valid_6, i_user_valid_5,
                        i_user_valid_4, i_user_valid_3, i_user_valid_2, i_user_valid_1};

    assign w_full      = &r_flag;
    // Every non-IDLE state presents a byte, so acceptance needs only ready.
    assign w_accept    = (r_state != S_IDLE) && i_tx_ready;
    assign w_data_byte = r_idx[0] ? r_buf[r_idx[3:1]][7:0] : r_buf[r_idx[3:1]][15:8];

`ifdef AD_FRAME_CRC8_EN
    function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
    assign w_csum_first = f_crc8(8'h00, r_seq);
    assign w_csum_step  = f_crc8(r_csum, w_data_byte);
`else
    assign w_csum_first = r_seq;
    assign w_csum_step  = r_csum + w_data_byte;
`endif

    // A valid landing on the clearing edge seeds the next frame instead of being lost.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_flag <= '0;
            for (int i = 0; i < 8; i++) begin
                r_hold[i] <= '0;
                r_buf[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_valid[i]) r_hold[i] <= w_data[i];
            end
            r_flag <= w_full ? w_valid : (r_flag | w_valid);
            if (w_full && r_state == S_IDLE) begin
                for (int i = 0; i < 8; i++) r_buf[i] <= r_hold[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_overrun <= w_full && (r_state != S_IDLE);
            if (w_full && (r_state != S_IDLE) && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_seq   <= '0;
            r_csum  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                case (r_state)
                    S_SEQ:   r_csum <= w_csum_first;
                    S_DATA: begin
                        r_csum <= w_csum_step;
                        r_idx  <= r_idx + 4'd1;
                    end
                    S_CSUM:  r_seq <= r_seq + 8'd1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        o_tx_data  = 8'h00;
        o_tx_valid = 1'b0;
        o_tx_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_full) w_next = S_HDR0;
            end
            S_HDR0: begin
                o_tx_valid = 1'b1;
                o_tx_data  = HEAD_0;
                if (i_tx_ready) w_next = S_HDR1;
            end
            S_HDR1: begin
                o_tx_valid = 1'b1;
                o_tx_data  = HEAD_1;
                if (i_tx_ready) w_next = S_SEQ;
            end
            S_SEQ: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_seq;
                if (i_tx_ready) w_next = S_DATA;
            end
            S_DATA: begin
                o_tx_valid = 1'b1;
                o_tx_data  = w_data_byte;
                if (i_tx_ready && r_idx == 4'd15) w_next = S_CSUM;
            end
            S_CSUM: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_csum;
                o_tx_last  = 1'b1;
                if (i_tx_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_overrun  = r_overrun;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_ad7606_frame_pack.sv
// tb/tb_ad7606_frame_pack.sv - scoreboard bench for ad7606_frame_pack (AD_FRAME_CRC8_EN selects CRC model).
module tb_ad7606_frame_pack;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ready;
    logic [7:0][15:0] tb_data;
    logic [7:0]       tb_valid;
    logic [7:0]       o_tx_data;
    logic             o_tx_valid;
    logic             o_tx_last;
    logic             o_overrun;
    logic [7:0]       o_drop_cnt;

    int checks   = 0;
    int failures = 0;
    int nbytes   = 0;
    int vcycles  = 0;
    int ovr_cnt  = 0;

    logic [8:0] exp_q [$];
    logic [7:0] m_seq = 8'h00;

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    logic       pl = 1'b0;

    always #5 clk = ~clk;

    ad7606_frame_pack dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_user_data_1  (tb_data[0]),
        .i_user_data_2  (tb_data[1]),
        .i_user_data_3  (tb_data[2]),
        .i_user_data_4  (tb_data[3]),
        .i_user_data_5  (tb_data[4]),
        .i_user_data_6  (tb_data[5]),
        .i_user_data_7  (tb_data[6]),
        .i_user_data_8  (tb_data[7]),
        .i_user_valid_1 (tb_valid[0]),
        .i_user_valid_2 (tb_valid[1]),
        .i_user_valid_3 (tb_valid[2]),
        .i_user_valid_4 (tb_valid[3]),
        .i_user_valid_5 (tb_valid[4]),
        .i_user_valid_6 (tb_valid[5]),
        .i_user_valid_7 (tb_valid[6]),
        .i_user_valid_8 (tb_valid[7]),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (ready),
        .o_tx_last      (o_tx_last),
        .o_overrun      (o_overrun),
        .o_drop_cnt     (o_drop_cnt)
    );

    function automatic logic [7:0] ref_crc8(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    // Byte monitor: handshake happens at the next posedge, so negedge sees settled values.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (o_overrun) ovr_cnt++;
            if (o_tx_valid) vcycles++;
            if (pv && !pr) begin
                checks++;
                if (o_tx_valid !== 1'b1 || o_tx_data !== pd || o_tx_last !== pl) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                             o_tx_valid, o_tx_data, o_tx_last, pd, pl);
                end
            end
            if (o_tx_valid && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got data=%h last=%b, need no byte", o_tx_data, o_tx_last);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    nbytes++;
                    if ({o_tx_last, o_tx_data} !== e) begin
                        failures++;
                        $display("FAIL frame_byte: got last=%b data=%h, need last=%b data=%h",
                                 o_tx_last, o_tx_data, e[8], e[7:0]);
                    end
                end
            end
            pv = o_tx_valid;
            pr = ready;
            pd = o_tx_data;
            pl = o_tx_last;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0][15:0] d);
        logic [7:0] cs;
        logic [7:0] b;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b0, m_seq});
`ifdef AD_FRAME_CRC8_EN
        cs = ref_crc8(8'h00, m_seq);
`else
        cs = m_seq;
`endif
        for (int i = 0; i < 16; i++) begin
            b = i[0] ? d[i/2][7:0] : d[i/2][15:8];
            exp_q.push_back({1'b0, b});
`ifdef AD_FRAME_CRC8_EN
            cs = ref_crc8(cs, b);
`else
            cs = cs + b;
`endif
        end
        exp_q.push_back({1'b1, cs});
        m_seq = m_seq + 8'd1;
    endtask

    task automatic drive_all(input logic [7:0][15:0] d);
        tb_data  = d;
        tb_valid = 8'hFF;
        tick(1);
        tb_valid = 8'h00;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        tick(2);
        checks++;
        if (exp_q.size() != 0 || o_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain: got %0d bytes left valid=%b, need 0 left valid=0",
                     name, exp_q.size(), o_tx_valid);
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        ready    = 1'b0;
        tb_valid = 8'h00;
        tb_data  = '0;
        tick(2);
        checks++;
        if ({o_tx_data, o_tx_valid, o_tx_last, o_overrun, o_drop_cnt} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h valid=%b last=%b ovr=%b drop=%0d, need all 0",
                     o_tx_data, o_tx_valid, o_tx_last, o_overrun, o_drop_cnt);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic;
        logic [7:0][15:0] d;
        int v0;
        for (int i = 0; i < 8; i++) d[i] = 16'h5555;
        ready = 1'b1;
        v0 = vcycles;
        push_frame(d);
        drive_all(d);
        wait_drain("basic", 100);
        checks++;
        if (vcycles - v0 != 20) begin
            failures++;
            $display("FAIL basic_valid_cycles: got %0d, need 20", vcycles - v0);
        end
        for (int i = 0; i < 8; i++) d[i] = 16'(i + 1);
        push_frame(d);
        drive_all(d);
        wait_drain("second", 100);
    endtask

    task automatic test_ready_toggle;
        logic [7:0][15:0] d;
        int n;
        for (int i = 0; i < 8; i++) d[i] = 16'h5555;
        ready = 1'b0;
        push_frame(d);
        drive_all(d);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            ready = ((n / 3) % 2) == 1;
            tick(1);
            n++;
        end
        ready = 1'b1;
        wait_drain("toggle", 20);
    endtask

    task automatic test_overrun;
        logic [7:0][15:0] d;
        int o0;
        for (int i = 0; i < 8; i++) d[i] = 16'hA000 | 16'(i * 16'h0111);
        ready = 1'b0;
        o0 = ovr_cnt;
        push_frame(d);
        drive_all(d);
        tick(3);
        for (int i = 0; i < 8; i++) d[i] = 16'hDEAD;
        drive_all(d);
        tick(3);
        for (int i = 0; i < 8; i++) d[i] = 16'hBEEF;
        drive_all(d);
        tick(3);
        checks++;
        if (ovr_cnt - o0 != 2) begin
            failures++;
            $display("FAIL overrun_pulses: got %0d, need 2", ovr_cnt - o0);
        end
        checks++;
        if (o_drop_cnt !== 8'd2) begin
            failures++;
            $display("FAIL drop_cnt: got %0d, need 2", o_drop_cnt);
        end
        ready = 1'b1;
        wait_drain("overrun", 100);
    endtask

    task automatic test_latency_overwrite;
        logic [7:0][15:0] d;
        for (int i = 0; i < 8; i++) d[i] = 16'h1100 + 16'(i);
        ready = 1'b1;
        push_frame(d);
        drive_all(d);
        checks++;
        if (o_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: got valid=%b, need 0", o_tx_valid);
        end
        tick(1);
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL latency_start: got valid=%b data=%h, need valid=1 data=a5", o_tx_valid, o_tx_data);
        end
        wait_drain("latency", 100);

        for (int i = 0; i < 8; i++) d[i] = 16'h7700 + 16'(i);
        tb_data  = d;
        tb_valid = 8'h7F;
        tick(1);
        tb_data[2] = 16'h1234;
        tb_valid   = 8'h04;
        tick(1);
        tb_valid = 8'h80;
        d[2] = 16'h1234;
        push_frame(d);
        tick(1);
        tb_valid = 8'h00;
        checks++;
        if (o_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL overwrite_early: got valid=%b, need 0", o_tx_valid);
        end
        tick(1);
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL overwrite_start: got valid=%b data=%h, need valid=1 data=a5", o_tx_valid, o_tx_data);
        end
        wait_drain("overwrite", 100);
    endtask

    task automatic test_reset_mid;
        logic [7:0][15:0] d;
        int b0;
        int n;
        for (int i = 0; i < 8; i++) d[i] = 16'hC3C3;
        ready = 1'b1;
        b0 = nbytes;
        push_frame(d);
        drive_all(d);
        n = 0;
        while (nbytes - b0 < 8 && n < 50) begin
            tick(1);
            n++;
        end
        checks++;
        if (nbytes - b0 < 8) begin
            failures++;
            $display("FAIL reset_mid_reach: got %0d bytes, need 8", nbytes - b0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_tx_data, o_tx_valid, o_tx_last, o_overrun, o_drop_cnt} !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got data=%h valid=%b last=%b ovr=%b drop=%0d, need all 0",
                     o_tx_data, o_tx_valid, o_tx_last, o_overrun, o_drop_cnt);
        end
        exp_q.delete();
        m_seq = 8'h00;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 8; i++) d[i] = 16'(i + 1);
        push_frame(d);
        drive_all(d);
        wait_drain("after_reset", 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ready_toggle();
        test_overrun();
        test_latency_overwrite();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
